// File: rtl/rptr_empty.sv
// Read-side pointer and empty-flag block for the async-comparator FIFO.
// This block keeps the binary read address for the RAM and the Gray read
// pointer for the direction comparator. It synchronises the comparator's
// almost-empty signal into a pessimistic empty flag, and returns read data.
// Optional feature: define RPTR_EMPTY_FWFT_EN to build a first-word-fall-through
// output stage. When the macro is undefined, a read request returns its data
// one cycle later.
module rptr_empty #(
  parameter int ASIZE = 4,
  parameter int DSIZE = 8
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             aempty_n,
  input  logic             rinc,
  input  logic [DSIZE-1:0] mem_rdata,
  output logic [ASIZE-1:0] raddr,
  output logic [ASIZE-1:0] rptr,
  output logic             rempty,
  output logic [DSIZE-1:0] rdata,
  output logic             rvalid,
  output logic             runderflow
);

  logic [ASIZE-1:0] rbin;
  logic [ASIZE-1:0] rbnext;
  logic [ASIZE-1:0] rgnext;
  logic             rempty2;
  logic             ren;

  function automatic logic [ASIZE-1:0] bin2gray(input logic [ASIZE-1:0] b);
    return (b >> 1) ^ b;
  endfunction

  // The pointer wraps naturally at 2**ASIZE because of the fixed width.
  assign rbnext = rbin + ASIZE'(ren);
  assign rgnext = bin2gray(rbnext);
  assign raddr  = rbin;

  // Binary and Gray read pointers advance together on every accepted pop.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin <= '0;
      rptr <= '0;
    end else begin
      rbin <= rbnext;
      rptr <= rgnext;
    end
  end

  // Two-flop synchroniser. It asserts empty immediately and releases it only
  // after two consecutive high samples.
  always_ff @(posedge rclk) begin
    if (rrst || !aempty_n) begin
      {rempty, rempty2} <= 2'b11;
    end else begin
      {rempty, rempty2} <= {rempty2, 1'b0};
    end
  end

`ifdef RPTR_EMPTY_FWFT_EN
  typedef enum logic {IDLE, HOLD} state_t;

  state_t state_q;
  state_t state_d;
  logic   pop_int;

  // Output-stage state register.
  always_ff @(posedge rclk) begin
    if (rrst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // The stage prefetches the head word whenever it is empty or being consumed.
  always_comb begin
    state_d = state_q;
    pop_int = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rempty) begin
          pop_int = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (rinc) begin
          if (!rempty) pop_int = 1'b1;
          else         state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ren    = pop_int;
  assign rvalid = (state_q == HOLD);

  // The head word is captured on each prefetch. A pop while nothing is held
  // counts as an underflow.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rdata      <= '0;
      runderflow <= 1'b0;
    end else begin
      if (pop_int)                  rdata      <= mem_rdata;
      if (rinc && state_q == IDLE)  runderflow <= 1'b1;
    end
  end
`else
  assign ren = rinc & ~rempty;

  // Data is returned one cycle after an accepted request and held until the
  // next read. Reading while empty sets the sticky underflow flag.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rdata      <= '0;
      rvalid     <= 1'b0;
      runderflow <= 1'b0;
    end else begin
      rvalid <= ren;
      if (ren)           rdata      <= mem_rdata;
      if (rinc & rempty) runderflow <= 1'b1;
    end
  end
`endif

endmodule
